// File: rtl/tick_timer.sv
// ----------------------------------------------------------------------------
// tick_timer : programmable down-counting timer with one-shot/periodic modes.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic [W-1:0] period,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         paused,
  output logic         expire
);

  localparam logic [1:0]   c_S_IDLE  = 2'd0;
  localparam logic [1:0]   c_S_RUN   = 2'd1;
  localparam logic [1:0]   c_S_PAUSE = 2'd2;
  localparam logic [W-1:0] c_ZERO    = '0;
  localparam logic [W-1:0] c_ONE     = W'(1);

  logic [1:0]   r_state;
  logic [W-1:0] r_count;
  logic [W-1:0] r_period;
  logic         r_mode;
  logic         r_expire;

  logic [1:0]   w_state_nxt;
  logic [W-1:0] w_count_nxt;
  logic [W-1:0] w_period_nxt;
  logic         w_mode_nxt;
  logic         w_expire_nxt;
  logic         w_period_zero;
  logic         w_terminal;

  assign w_period_zero = (period == c_ZERO);
  assign w_terminal    = (r_count == c_ONE);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_S_IDLE;
      r_count  <= c_ZERO;
      r_period <= c_ZERO;
      r_mode   <= 1'b0;
      r_expire <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_period <= w_period_nxt;
      r_mode   <= w_mode_nxt;
      r_expire <= w_expire_nxt;
    end
  end

  // Next-state and datapath update; stop outranks start, start outranks tick
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_period_nxt = r_period;
    w_mode_nxt   = r_mode;
    w_expire_nxt = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (!stop && start && !w_period_zero) begin
          w_period_nxt = period;
          w_mode_nxt   = periodic;
          w_count_nxt  = period;
          w_state_nxt  = c_S_RUN;
        end
      end
      c_S_RUN: begin
        if (stop) begin
          w_state_nxt = c_S_PAUSE;
        end else if (start) begin
          if (w_period_zero) begin
            w_count_nxt = c_ZERO;
            w_state_nxt = c_S_IDLE;
          end else begin
            w_period_nxt = period;
            w_mode_nxt   = periodic;
            w_count_nxt  = period;
          end
        end else if (tick) begin
          if (w_terminal) begin
            w_expire_nxt = 1'b1;
            if (r_mode) begin
              w_count_nxt = r_period;
            end else begin
              w_count_nxt = c_ZERO;
              w_state_nxt = c_S_IDLE;
            end
          end else begin
            w_count_nxt = r_count - c_ONE;
          end
        end
      end
      c_S_PAUSE: begin
        if (stop) begin
          w_count_nxt = c_ZERO;
          w_state_nxt = c_S_IDLE;
        end else if (start) begin
          w_state_nxt = c_S_RUN;
        end
      end
      default: begin
        w_count_nxt = c_ZERO;
        w_state_nxt = c_S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registers only
  always_comb begin
    busy   = (r_state == c_S_RUN);
    paused = (r_state == c_S_PAUSE);
    count  = r_count;
    expire = r_expire;
  end

endmodule

`default_nettype wire

// File: tb/tb_tick_timer.sv
// ----------------------------------------------------------------------------
// tb_tick_timer : directed self-checking bench for tick_timer (W=16 and W=4).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tick_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0, start = 1'b0, stop = 1'b0, periodic = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] count;
  logic        busy, paused, expire;

  logic        tick4 = 1'b0, start4 = 1'b0, stop4 = 1'b0, periodic4 = 1'b0;
  logic [3:0]  period4 = '0;
  logic [3:0]  count4;
  logic        busy4, paused4, expire4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tick_timer #(.W(16)) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .periodic(periodic), .period(period), .count(count), .busy(busy),
    .paused(paused), .expire(expire)
  );

  tick_timer #(.W(4)) u_dut4 (
    .clk(clk), .reset(reset), .tick(tick4), .start(start4), .stop(stop4),
    .periodic(periodic4), .period(period4), .count(count4), .busy(busy4),
    .paused(paused4), .expire(expire4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of control inputs, then sample just after the edge
  task automatic cyc(input logic t, input logic s, input logic p);
    tick = t; start = s; stop = p;
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] c, input logic b,
                         input logic pz, input logic e);
    check({tag, ".count"},  32'(count),  32'(c));
    check({tag, ".busy"},   32'(busy),   32'(b));
    check({tag, ".paused"}, 32'(paused), 32'(pz));
    check({tag, ".expire"}, 32'(expire), 32'(e));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("reset", 16'd0, 1'b0, 1'b0, 1'b0);

    // One-shot, period 3, tick every 4th cycle
    period = 16'd3; periodic = 1'b0;
    cyc(0, 1, 0);
    chk_all("os_start", 16'd3, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) cyc(0, 0, 0);
      cyc(1, 0, 0);
      chk_all($sformatf("os_tick%0d", k), 16'(3 - k), (k < 3), 1'b0, (k == 3));
    end
    cyc(0, 0, 0);
    chk_all("os_after", 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) begin
      cyc(1, 0, 0);
      check("os_no_more", 32'(expire), 32'd0);
    end

    // Periodic, period 2, tick held high
    period = 16'd2; periodic = 1'b1;
    cyc(0, 1, 0);
    chk_all("per_start", 16'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 0, 0);
      chk_all($sformatf("per_t%0d", i), (i % 2 == 1) ? 16'd1 : 16'd2, 1'b1, 1'b0, (i % 2 == 0));
    end
    cyc(0, 0, 1);
    chk_all("per_pause", 16'd2, 1'b0, 1'b1, 1'b0);
    cyc(0, 0, 1);
    chk_all("per_abort", 16'd0, 1'b0, 1'b0, 1'b0);

    // Pause/resume, period 5
    period = 16'd5; periodic = 1'b0;
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("pr_two", 32'(count), 32'd3);
    cyc(0, 0, 1);
    chk_all("pr_pause", 16'd3, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1, 0, 0);
    chk_all("pr_frozen", 16'd3, 1'b0, 1'b1, 1'b0);
    period = 16'd9; periodic = 1'b1;
    cyc(0, 1, 0);
    chk_all("pr_resume", 16'd3, 1'b1, 1'b0, 1'b0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("pr_one", 32'(count), 32'd1);
    cyc(1, 0, 0);
    chk_all("pr_expire", 16'd0, 1'b0, 1'b0, 1'b1);

    // Stop on terminal tick wins; then stop in PAUSE aborts
    period = 16'd2; periodic = 1'b0;
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    chk_all("term_stop", 16'd1, 1'b0, 1'b1, 1'b0);
    cyc(0, 0, 1);
    chk_all("pause_abort", 16'd0, 1'b0, 1'b0, 1'b0);

    // Restart in RUN beats same-cycle tick
    period = 16'd6;
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("rs_four", 32'(count), 32'd4);
    period = 16'd7;
    cyc(1, 1, 0);
    chk_all("rs_reload", 16'd7, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);

    // Start with period 0 is ignored
    period = 16'd0;
    cyc(0, 1, 0);
    chk_all("zero_start", 16'd0, 1'b0, 1'b0, 1'b0);

    // Period 1 with tick held: expire every cycle; reset kills terminal tick
    period = 16'd1; periodic = 1'b1;
    cyc(0, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 0, 0);
      chk_all($sformatf("p1_t%0d", i), 16'd1, 1'b1, 1'b0, 1'b1);
    end
    reset = 1'b1;
    cyc(1, 0, 0);
    reset = 1'b0;
    chk_all("rst_term", 16'd0, 1'b0, 1'b0, 1'b0);

    // W=4, full-scale period 15, periodic
    period4 = 4'd15; periodic4 = 1'b1; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    check("w4_start", 32'(count4), 32'd15);
    tick4 = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("w4_c%0d", i), 32'(count4), (i % 15 == 0) ? 32'd15 : 32'(15 - (i % 15)));
      check($sformatf("w4_e%0d", i), 32'(expire4), 32'(i % 15 == 0));
    end
    tick4 = 1'b0;
    check("w4_busy", 32'(busy4), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
